dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single DataMem instance between the processor datapath (core port) and a debug/loader port (dbg port).
- The dbg port preloads operands and reads back results around program runs.
- Registered owner FSM with core priority at idle, a bounded-tenure fairness rule, and a req/gnt handshake.
- Synchronous read-data return to each port.

Parameters:
- AW, 8, address width (DataMem is 256-deep)
- DW, 8, data width
- MAX_HOLD, 4, max consecutive transfers granted to one owner while the other port is requesting (legal range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- c_req  in  1  core request; held with operands until transfer completes
- c_we  in  1  core write enable (1 = write, 0 = read)
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_gnt  out  1  core granted this cycle
- c_rvalid  out  1  core read data valid (one-cycle pulse)
- c_rdata  out  DW  core read data
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  dbg port, same semantics as core
- d_gnt, d_rvalid, d_rdata  out  1/1/DW  dbg port, same semantics as core
- mem_we  out  1  to DataMem WriteEn
- mem_addr  out  AW  to DataMem DataAddress
- mem_wdata  out  DW  to DataMem DataIn
- mem_rdata  in  DW  from DataMem DataOut (combinational read)
- owner  out  2  current owner state: 0 IDLE, 1 CORE, 2 DBG

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, hold_cnt=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0. Because mem_we is decoded from state, it is 0 immediately.
- FSM states: IDLE, CORE, DBG. owner output reflects the state register.
- Grant decode (combinational from state):
  - c_gnt = (state==CORE) & c_req
  - d_gnt = (state==DBG) & d_req
- Transfer rule: a transfer completes on the rising edge where req & gnt are both 1 for a port.
- Memory mux in CORE/DBG: mem_addr, mem_wdata and mem_we come from the owner's live inputs, with mem_we = owner_req & owner_we.
- Memory mux in IDLE: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return: on a completing read, capture mem_rdata into x_rdata at that edge and pulse x_rvalid=1 for exactly the next cycle. x_rdata holds its value until the next read completes on that port.
- Write return: a completing write produces no rvalid.
- Latency: the first request from IDLE takes 1 cycle to grant, so the transfer completes on the 2nd edge after req is raised. Back-to-back transfers by the owner complete 1 per cycle.
- IDLE transitions:
  - c_req → CORE (core wins a simultaneous request)
  - else d_req → DBG
  - else stay IDLE
  - hold_cnt=0 in all cases
- Owner X ∈ {CORE, DBG}, other port Y, evaluated each edge:
  - If X completes a transfer, hold_cnt increments, saturating at MAX_HOLD.
  - Next state = Y if Y_req and (hold_cnt+1 ≥ MAX_HOLD, or X_req=0).
  - Else X if X_req.
  - Else IDLE.
  - Any change of state clears hold_cnt to 0.
- Owner drops req while granted: no transfer that cycle. Move to Y if Y_req, else IDLE. No bubble when switching directly between owners.
- Uncontested owner (Y_req=0): keeps ownership indefinitely. hold_cnt still counts, saturating.
- Requester dropping req before gnt is legal; no side effects.
- Requester changing addr/we/wdata while req=1 and gnt=0 is legal; only values at the completing edge matter.
- Reset asserted mid-transfer: the transfer is aborted. Any write that had not reached the clock edge does not occur. Outputs go to reset values immediately.

Test Plan:
- Reset then single core write, c_addr=0x10, c_wdata=0xA5 → c_gnt high from cycle 1. DataMem[0x10]=0xA5 after the 2nd edge. c_rvalid stays 0.
- Core read of 0x10 after the previous write → c_rvalid pulses for 1 cycle with c_rdata=0xA5. c_rdata holds 0xA5 afterwards.
- c_req and d_req raised together from IDLE → CORE granted first. d_gnt stays 0 for exactly 4 core transfers (MAX_HOLD=4), then DBG is granted with no idle cycle. After 4 dbg transfers, ownership returns to CORE.
- Dbg sole requester streaming writes 0x00..0x0F to addresses 0x20..0x2F → owner stays DBG and one write completes per cycle. A later core read of 0x2F returns 0x0F.
- Owner drops req mid-tenure while the other port is requesting → switch on the next edge with hold_cnt=0. With neither port requesting → owner=IDLE and mem_we=0.
- rst driven low during a granted core write, asynchronously before the edge → mem_we=0 immediately, the DataMem location is unchanged, owner=0, and all rvalid outputs are 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one DataMem between the core and debug/loader ports using a registered owner FSM.
// Latency: a grant follows a request from IDLE by one cycle. Reads return one cycle after the transfer edge. A port waits while the other port owns the memory.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CORE = 2'd1,
    S_DBG  = 2'd2
  } state_t;

  localparam logic [4:0] MAXH = 5'(MAX_HOLD);

  state_t          state_q, state_d;
  logic [3:0]      hold_q, hold_d;
  logic            c_rvalid_q, d_rvalid_q;
  logic [DW-1:0]   c_rdata_q, d_rdata_q;
  logic            x_req, y_req;
  logic [4:0]      hold_inc;

  assign c_gnt = (state_q == S_CORE) & c_req;
  assign d_gnt = (state_q == S_DBG) & d_req;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_CORE: begin
        mem_we    = c_req & c_we;
        mem_addr  = c_addr;
        mem_wdata = c_wdata;
      end
      S_DBG: begin
        mem_we    = d_req & d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // x is the current owner, y the other port; hold_q counts completed transfers this tenure.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    x_req    = 1'b0;
    y_req    = 1'b0;
    hold_inc = {1'b0, hold_q} + 5'd1;
    case (state_q)
      S_CORE: begin
        x_req = c_req;
        y_req = d_req;
      end
      S_DBG: begin
        x_req = d_req;
        y_req = c_req;
      end
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      hold_d = '0;
      if (c_req)      state_d = S_CORE;
      else if (d_req) state_d = S_DBG;
      else            state_d = S_IDLE;
    end else if (y_req && ((hold_inc >= MAXH) || !x_req)) begin
      state_d = (state_q == S_CORE) ? S_DBG : S_CORE;
      hold_d  = '0;
    end else if (x_req) begin
      hold_d = (hold_inc >= MAXH) ? 4'(MAX_HOLD) : hold_inc[3:0];
    end else begin
      state_d = S_IDLE;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      c_rvalid_q <= c_gnt & ~c_we;
      d_rvalid_q <= d_gnt & ~d_we;
      if (c_gnt && !c_we) c_rdata_q <= mem_rdata;
      if (d_gnt && !d_we) d_rdata_q <= mem_rdata;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign owner    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural DataMem and arbitration model.
module tb_dmem_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int LIMIT    = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic       c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
  logic [7:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] owner;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // DataMem: combinational read, write on the clock edge
  logic [7:0] dmem [256];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } op_t;

  op_t        cq[$], dq[$];
  logic [7:0] c_exp[$], d_exp[$];
  logic [7:0] model_mem [256];
  int         total = 0, bad = 0;
  int         m_state = 0, m_ten = 0, gap_pct = 0;
  bit         model_en = 0, drive_en = 0, mon_en = 0;
  bit         c_done = 0, d_done = 0;
  bit         eg_c, eg_d, mine, other;
  logic [7:0] saved;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus: present the head op of each port queue, with optional random request gaps
  always @(negedge clk) begin
    c_done = c_req & c_gnt;
    d_done = d_req & d_gnt;
  end

  always @(posedge clk) if (drive_en) begin
    #1;
    if (c_done && cq.size() > 0) void'(cq.pop_front());
    if (d_done && dq.size() > 0) void'(dq.pop_front());
    c_done = 0;
    d_done = 0;
    if (cq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      c_req = 1'b1; c_we = cq[0].we; c_addr = cq[0].addr; c_wdata = cq[0].wdata;
    end else begin
      c_req = 1'b0; c_addr = 8'($urandom); c_wdata = 8'($urandom);
    end
    if (dq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
    end else begin
      d_req = 1'b0; d_addr = 8'($urandom); d_wdata = 8'($urandom);
    end
  end

  // Reference model: owner, tenure length in transfers, and memory contents
  always @(negedge clk) if (model_en) begin
    eg_c = (m_state == 1) && c_req;
    eg_d = (m_state == 2) && d_req;
    chk("owner", 32'(owner), m_state);
    chk("c_gnt", 32'(c_gnt), 32'(eg_c));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("mem_we", 32'(mem_we), 32'((eg_c && c_we) || (eg_d && d_we)));
    if (m_state == 1) begin
      chk("mem_addr", 32'(mem_addr), 32'(c_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(c_wdata));
    end else if (m_state == 2) begin
      chk("mem_addr", 32'(mem_addr), 32'(d_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(d_wdata));
    end else begin
      chk("idle_addr", 32'(mem_addr), 0);
      chk("idle_wdata", 32'(mem_wdata), 0);
    end
    if (eg_c) begin
      if (c_we) model_mem[c_addr] = c_wdata;
      else      c_exp.push_back(model_mem[c_addr]);
    end
    if (eg_d) begin
      if (d_we) model_mem[d_addr] = d_wdata;
      else      d_exp.push_back(model_mem[d_addr]);
    end
    if (m_state == 0) begin
      m_ten   = 0;
      m_state = c_req ? 1 : (d_req ? 2 : 0);
    end else begin
      mine  = (m_state == 1) ? c_req : d_req;
      other = (m_state == 1) ? d_req : c_req;
      if (mine) m_ten++;
      if (other && (m_ten >= MAX_HOLD || !mine)) begin
        m_state = 3 - m_state;
        m_ten   = 0;
      end else if (!mine) begin
        m_state = 0;
        m_ten   = 0;
      end
    end
  end

  // Monitor: every rvalid pulse consumes one expected read result
  always @(posedge clk) if (mon_en) begin
    #2;
    if (c_rvalid) begin
      if (c_exp.size() == 0) chk("c_rvalid_unexpected", 32'(c_rvalid), 0);
      else chk("c_rdata", 32'(c_rdata), 32'(c_exp.pop_front()));
    end
    if (d_rvalid) begin
      if (d_exp.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 0);
      else chk("d_rdata", 32'(d_rdata), 32'(d_exp.pop_front()));
    end
  end

  task automatic wait_idle(input string nm);
    int left;
    left = cq.size() + dq.size();
    for (int i = 0; i < LIMIT && left != 0; i++) begin
      @(posedge clk);
      left = cq.size() + dq.size();
    end
    chk({nm, "_drain"}, 32'(left), 0);
    cq.delete();
    dq.delete();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]      = 8'(i * 7 + 3);
      model_mem[i] = 8'(i * 7 + 3);
    end
    #3;
    chk("rst_owner", 32'(owner), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_c_rvalid", 32'(c_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_c_rdata", 32'(c_rdata), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_en = 1; mon_en = 1; drive_en = 1;
    #3;

    cq.push_back('{we: 1'b1, addr: 8'h10, wdata: 8'hA5});
    wait_idle("core_write");
    chk("mem_10", 32'(dmem[8'h10]), 32'h A5);

    cq.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    wait_idle("core_read");
    chk("c_rdata_hold", 32'(c_rdata), 32'hA5);
    #3;

    for (int i = 0; i < 8; i++) begin
      cq.push_back('{we: 1'b1, addr: 8'(8'h40 + i), wdata: 8'(i + 8'h80)});
      dq.push_back('{we: 1'b1, addr: 8'(8'h48 + i), wdata: 8'(i + 8'hC0)});
    end
    wait_idle("contend");

    for (int i = 0; i < 16; i++)
      dq.push_back('{we: 1'b1, addr: 8'(8'h20 + i), wdata: 8'(i)});
    wait_idle("dbg_stream");
    cq.push_back('{we: 1'b0, addr: 8'h2F, wdata: 8'h00});
    wait_idle("read_2f");
    chk("c_rdata_2f", 32'(c_rdata), 32'h0F);

    gap_pct = 25;
    for (int i = 0; i < 200; i++) begin
      cq.push_back('{we: 1'($urandom), addr: 8'(8'h60 + $urandom_range(15)), wdata: 8'($urandom)});
      dq.push_back('{we: 1'($urandom), addr: 8'(8'h60 + $urandom_range(15)), wdata: 8'($urandom)});
    end
    wait_idle("random");
    gap_pct = 0;
    chk("c_exp_left", 32'(c_exp.size()), 0);
    chk("d_exp_left", 32'(d_exp.size()), 0);

    // Asynchronous reset in the middle of a granted core write
    model_en = 0; drive_en = 0; mon_en = 0;
    saved = dmem[8'h50];
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h50; c_wdata = ~saved;
    @(posedge clk); #1;
    chk("pre_rst_gnt", 32'(c_gnt), 1);
    chk("pre_rst_we", 32'(mem_we), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_we", 32'(mem_we), 0);
    chk("arst_owner", 32'(owner), 0);
    chk("arst_c_gnt", 32'(c_gnt), 0);
    chk("arst_c_rvalid", 32'(c_rvalid), 0);
    chk("arst_d_rvalid", 32'(d_rvalid), 0);
    chk("arst_c_rdata", 32'(c_rdata), 0);
    @(posedge clk); #1;
    chk("arst_mem_50", 32'(dmem[8'h50]), 32'(saved));
    chk("arst_owner_hold", 32'(owner), 0);
    c_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_state = 0; m_ten = 0; c_done = 0; d_done = 0;
    c_exp.delete(); d_exp.delete();
    @(posedge clk);
    model_en = 1; mon_en = 1; drive_en = 1;
    #3;
    dq.push_back('{we: 1'b0, addr: 8'h50, wdata: 8'h00});
    wait_idle("post_rst");
    chk("post_rst_d_rdata", 32'(d_rdata), 32'(saved));

    for (int i = 0; i < 256; i++)
      if (dmem[i] !== model_mem[i]) chk("final_mem", 32'(dmem[i]), 32'(model_mem[i]));
    chk("final_exp", 32'(c_exp.size() + d_exp.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
